// File: rtl/led_green_fader_if.sv
// Pattern/LED bundle between the green-LED PIO side and the fader.
// The master drives the target pattern and mode; the slave returns the LED drive and status.
interface led_green_fader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pattern_in;
  logic             fade_en;
  logic [WIDTH-1:0] led_out;
  logic             busy;
  logic             fade_done;

  modport master (
    output pattern_in,
    output fade_en,
    input  led_out,
    input  busy,
    input  fade_done
  );

  modport slave (
    input  pattern_in,
    input  fade_en,
    output led_out,
    output busy,
    output fade_done
  );
endinterface

// File: rtl/led_green_fader.sv
// Turns every change of the PIO LED pattern into a linear PWM cross-fade from the
// old pattern to the new one; fade_en=0 bypasses the fade with a two-clock path.
module led_green_fader #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  led_green_fader_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FADE = 1'b1
  } state_t;

  localparam int                  SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

  logic [WIDTH-1:0]    r_pat_q;
  logic [WIDTH-1:0]    r_cur;
  logic [WIDTH-1:0]    r_old;
  logic [WIDTH-1:0]    r_new;
  logic [WIDTH-1:0]    r_led;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [SW-1:0]       r_step_cnt;
  state_t              r_state;
  logic                r_busy;
  logic                r_fade_done;

  logic                w_tick;
  logic [WIDTH-1:0]    w_drive;

  assign w_tick = (r_step_cnt == STEP_LAST);

  // Fading-in bits are lit while the PWM phase is below the level, fading-out bits above it.
  always_comb begin
    w_drive = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_old[i] == r_new[i]) begin
        w_drive[i] = r_new[i];
      end else if (r_new[i]) begin
        w_drive[i] = (r_pwm_cnt < r_level);
      end else begin
        w_drive[i] = (r_pwm_cnt >= r_level);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat_q     <= '0;
      r_cur       <= '0;
      r_old       <= '0;
      r_new       <= '0;
      r_led       <= '0;
      r_level     <= '0;
      r_pwm_cnt   <= '0;
      r_step_cnt  <= '0;
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_fade_done <= 1'b0;
    end else begin
      r_pat_q     <= bus.pattern_in;
      r_fade_done <= 1'b0;
      if (!bus.fade_en) begin
        // Bypass wins over any fade in progress and never reports completion.
        r_state    <= S_IDLE;
        r_cur      <= r_pat_q;
        r_led      <= r_pat_q;
        r_level    <= '0;
        r_pwm_cnt  <= '0;
        r_step_cnt <= '0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_led <= r_cur;
            if (r_pat_q != r_cur) begin
              r_old      <= r_cur;
              r_new      <= r_pat_q;
              r_level    <= '0;
              r_pwm_cnt  <= '0;
              r_step_cnt <= '0;
              r_state    <= S_FADE;
              r_busy     <= 1'b1;
            end
          end
          S_FADE: begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_tick) begin
              r_step_cnt <= '0;
              if (r_level == LEVEL_MAX) begin
                r_cur       <= r_new;
                r_led       <= r_new;
                r_level     <= '0;
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_fade_done <= 1'b1;
              end else begin
                r_level <= r_level + 1'b1;
                r_led   <= w_drive;
              end
            end else begin
              r_step_cnt <= r_step_cnt + 1'b1;
              r_led      <= w_drive;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.led_out   = r_led;
  assign bus.busy      = r_busy;
  assign bus.fade_done = r_fade_done;

endmodule

// File: tb/tb_led_green_fader.sv
// Bench for led_green_fader: directed fade/bypass/reset scenarios followed by random
// stimulus, all compared every cycle against an elapsed-time reference model.
module tb_led_green_fader;

  localparam int WIDTH    = 8;
  localparam int PWM_BITS = 3;
  localparam int STEP_DIV = 2;
  localparam int PERIOD   = 1 << PWM_BITS;
  localparam int FADE_LEN = PERIOD * STEP_DIV;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  led_green_fader_if #(.WIDTH(WIDTH)) bus ();

  led_green_fader #(
    .WIDTH   (WIDTH),
    .PWM_BITS(PWM_BITS),
    .STEP_DIV(STEP_DIV)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a fade is described only by its endpoints and the number of
  // cycles spent fading; brightness level and PWM phase follow from that count.
  logic [WIDTH-1:0] m_pat_q, m_cur, m_old, m_new, m_led;
  bit               m_fading, m_busy, m_done;
  int               m_k;

  always @(posedge clk or negedge reset_n) begin : model
    logic [WIDTH-1:0] prev;
    int pwm, lvl;
    if (!reset_n) begin
      m_pat_q = '0; m_cur = '0; m_old = '0; m_new = '0; m_led = '0;
      m_fading = 0; m_busy = 0; m_done = 0; m_k = 0;
    end else begin
      prev    = m_pat_q;
      m_pat_q = bus.pattern_in;
      m_done  = 0;
      if (!bus.fade_en) begin
        m_fading = 0; m_busy = 0; m_cur = prev; m_led = prev;
      end else if (!m_fading) begin
        m_led = m_cur;
        if (prev != m_cur) begin
          m_old = m_cur; m_new = prev; m_fading = 1; m_busy = 1; m_k = 0;
        end
      end else begin
        pwm = m_k % PERIOD;
        lvl = m_k / STEP_DIV;
        if (m_k == FADE_LEN - 1) begin
          m_cur = m_new; m_led = m_new; m_fading = 0; m_busy = 0; m_done = 1;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (m_old[i] == m_new[i]) m_led[i] = m_new[i];
            else if (m_new[i])        m_led[i] = (pwm < lvl);
            else                      m_led[i] = (pwm >= lvl);
          end
        end
        m_k++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("led_out",   32'(bus.led_out),   32'(m_led));
      check("busy",      32'(bus.busy),      32'(m_busy));
      check("fade_done", 32'(bus.fade_done), 32'(m_done));
      if (bus.fade_done === 1'b1) done_cnt++;
    end
  end

  // Inputs always change 2 time units after a falling edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  int d0;

  initial begin
    bus.pattern_in = 8'hFF;
    bus.fade_en    = 1'b1;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    wait_cyc(3);
    check("rst_led",  32'(bus.led_out),   32'h00);
    check("rst_busy", 32'(bus.busy),      32'h0);
    check("rst_done", 32'(bus.fade_done), 32'h0);
    reset_n = 1'b1;
    wait_cyc(1);
    check("start_busy_1", 32'(bus.busy), 32'h0);
    wait_cyc(1);
    check("start_busy_2", 32'(bus.busy), 32'h1);
    wait_cyc(FADE_LEN + 2);

    // Fade in on the low nibble from an all-off pattern.
    bus.fade_en = 1'b0; bus.pattern_in = 8'h00;
    wait_cyc(3);
    bus.fade_en = 1'b1; bus.pattern_in = 8'h0F;
    wait_cyc(FADE_LEN + 4);
    check("fade_on_final", 32'(bus.led_out), 32'h0F);
    check("fade_on_idle",  32'(bus.busy),    32'h0);

    // Mixed fade: some bits in, some out, some steady.
    bus.fade_en = 1'b0; bus.pattern_in = 8'hF0;
    wait_cyc(3);
    bus.fade_en = 1'b1; bus.pattern_in = 8'h3C;
    wait_cyc(FADE_LEN + 4);
    check("mixed_final", 32'(bus.led_out), 32'h3C);

    // Pattern change mid-fade: two complete fades, two pulses.
    bus.fade_en = 1'b0; bus.pattern_in = 8'h00;
    wait_cyc(3);
    d0 = done_cnt;
    bus.fade_en = 1'b1; bus.pattern_in = 8'hFF;
    wait_cyc(2 + 5);
    bus.pattern_in = 8'h01;
    wait_cyc(2 * FADE_LEN + 8);
    check("midchg_pulses", 32'(done_cnt - d0), 32'd2);
    check("midchg_final",  32'(bus.led_out),   32'h01);

    // Bypass abort mid-fade.
    d0 = done_cnt;
    bus.pattern_in = 8'hFE;
    wait_cyc(2 + 6);
    bus.fade_en = 1'b0;
    wait_cyc(2);
    check("abort_led",    32'(bus.led_out),   32'hFE);
    check("abort_busy",   32'(bus.busy),      32'h0);
    check("abort_pulses", 32'(done_cnt - d0), 32'd0);
    bus.pattern_in = 8'hA5;
    wait_cyc(2);
    check("bypass_a5", 32'(bus.led_out), 32'hA5);

    // Reset asserted mid-fade takes effect without a clock edge.
    bus.fade_en = 1'b1; bus.pattern_in = 8'h5A;
    wait_cyc(2 + 9);
    reset_n = 1'b0;
    #1;
    check("midrst_led",  32'(bus.led_out),   32'h00);
    check("midrst_busy", 32'(bus.busy),      32'h0);
    check("midrst_done", 32'(bus.fade_done), 32'h0);
    wait_cyc(1);
    reset_n = 1'b1;

    // Random patterns, occasional bypass toggles and reset pulses.
    for (int c = 0; c < 1500; c++) begin
      wait_cyc(1);
      reset_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0)  bus.pattern_in = WIDTH'($urandom);
      if ($urandom_range(0, 59) == 0) bus.fade_en = ~bus.fade_en;
    end
    reset_n = 1'b1;
    bus.fade_en = 1'b1;
    wait_cyc(2 * FADE_LEN + 6);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
